dcm_ramp_arbiter: RTL
=====================

DCM_RAMP_ARBITER -- requirements
Module: dcm_ramp_arbiter

Interface
REQ-001 Parameter: MAXIMUM_MULTIPLIER, default 64, upper clamp for every multiplier value.
REQ-002 Parameter: MINIMUM_MULTIPLIER, default 2, lower clamp for every multiplier value.
REQ-003 Parameter: INITIAL_MULTIPLIER, default 16, multiplier the DCM holds out of configuration.
REQ-004 Parameter: SETTLE_CYCLES, default 1024, lock-settle wait after each programmed step.
REQ-005 Parameter: TIMEOUT_CYCLES, default 4096, maximum wait for prog_done.
REQ-006 Clocking is decided: one clock; reset is asynchronous and active-high.
REQ-007 Port: clk  in  1  single clock for all logic.
REQ-008 Port: reset  in  1  asynchronous, active-high.
REQ-009 Port: host_valid  in  1  one-cycle request carrying a new host target.
REQ-010 Port: host_mult  in  8  requested host multiplier.
REQ-011 Port: host_ack  out  1  one-cycle pulse confirming the request was latched.
REQ-012 Port: therm_alarm  in  1  level input; thermal throttle is active while high.
REQ-013 Port: therm_mult  in  8  throttle ceiling multiplier.
REQ-014 Port: prog_start  out  1  one-cycle pulse telling the DCM programmer to load prog_mult.
REQ-015 Port: prog_mult  out  8  multiplier being programmed.
REQ-016 Port: prog_busy  in  1  programmer busy; prog_start is never issued while this is high.
REQ-017 Port: prog_done  in  1  one-cycle pulse marking programming complete.
REQ-018 Port: current_mult  out  8  last multiplier confirmed by prog_done.
REQ-019 Port: target_mult  out  8  effective target (see REQ-022).
REQ-020 Port: ramping  out  1  high whenever the state is not IDLE.
REQ-021 Port: prog_error  out  1  sticky timeout flag.

Function
REQ-022 Multiplier arithmetic and target:
- Every incoming multiplier is clamped to [MINIMUM_MULTIPLIER, MAXIMUM_MULTIPLIER] using 8-bit unsigned compares.
- host_tgt is the clamped host_mult latched on host_valid.
- Effective target = therm_alarm ? min(host_tgt, clamp(therm_mult)) : host_tgt.
- Effective target is registered onto target_mult with 1-cycle latency.
REQ-023 Host handshake: host_valid is accepted in every state; host_ack pulses in the cycle after host_valid.
REQ-024 State machine: IDLE, ISSUE, WAIT_DONE, SETTLE.
REQ-025 IDLE -> ISSUE when current_mult != target_mult and prog_busy = 0.
- Upward step: prog_mult = current_mult + 1 (single-step ramp).
- Downward step: prog_mult = target_mult (direct drop).
REQ-026 ISSUE: prog_start = 1 for exactly one cycle; prog_mult is held stable until WAIT_DONE exits; next state is WAIT_DONE.
REQ-027 WAIT_DONE on prog_done: current_mult <= prog_mult, timer cleared, next state SETTLE.
REQ-028 WAIT_DONE timeout: after TIMEOUT_CYCLES cycles without prog_done, set prog_error, leave current_mult unchanged, go to IDLE.
REQ-029 SETTLE counts SETTLE_CYCLES cycles, then goes to IDLE.
- Exception: if target_mult < current_mult, SETTLE aborts to IDLE on the next cycle (throttle priority).
REQ-030 A target change during ISSUE or WAIT_DONE does not abort the step in flight; it is re-evaluated in IDLE.
REQ-031 prog_done while not in WAIT_DONE is ignored.
REQ-032 host_valid in the same cycle as prog_done: both are applied.
REQ-033 prog_error does not block further steps.

Reset
REQ-034 On reset assertion, the block immediately enters IDLE with these values:
- current_mult = host_tgt = target_mult = INITIAL_MULTIPLIER (clamped)
- prog_mult = INITIAL_MULTIPLIER
- prog_start = host_ack = prog_error = ramping = 0
- all counters = 0
REQ-035 Reset mid-WAIT_DONE abandons the step; a late prog_done after release is ignored per REQ-031.

Verification
REQ-036 Up-ramp: host_mult=19 from reset, programmer answers prog_done 5 cycles after each prog_start:
- prog_start pulses with prog_mult 17, 18, 19, spaced by SETTLE_CYCLES
- current_mult ends at 19; ramping then falls.
REQ-037 Throttle: current_mult=40, then therm_alarm=1 with therm_mult=20:
- a single step issues with prog_mult=20
- if the alarm rises during SETTLE, SETTLE aborts within 1 cycle
- when the alarm falls, the ramp climbs 21..40.
REQ-038 Clamp: host_mult=200 gives target_mult=64; host_mult=0 gives target_mult=2; host_ack is asserted 1 cycle after host_valid in both cases.
REQ-039 Timeout: prog_done withheld:
- prog_error rises exactly TIMEOUT_CYCLES cycles after WAIT_DONE entry
- current_mult stays unchanged
- the step retries from IDLE.
REQ-040 Busy/reset: prog_busy=1 holds the block in IDLE with no prog_start. Reset asserted mid-WAIT_DONE gives current_mult=16 and no update from a subsequent prog_done.

Source files
------------

// File: rtl/dcm_ramp_arbiter.sv
// DCM multiplier ramp arbiter: merges the host target with a thermal ceiling and drives the
// DCM programmer one step at a time (single-step up, direct drop down) with settle and timeout.
module dcm_ramp_arbiter #(
  parameter int MAXIMUM_MULTIPLIER = 64,
  parameter int MINIMUM_MULTIPLIER = 2,
  parameter int INITIAL_MULTIPLIER = 16,
  parameter int SETTLE_CYCLES      = 1024,
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_valid,
  input  logic [7:0] host_mult,
  output logic       host_ack,
  input  logic       therm_alarm,
  input  logic [7:0] therm_mult,
  output logic       prog_start,
  output logic [7:0] prog_mult,
  input  logic       prog_busy,
  input  logic       prog_done,
  output logic [7:0] current_mult,
  output logic [7:0] target_mult,
  output logic       ramping,
  output logic       prog_error
);

  localparam logic [7:0] MAX_M        = 8'(MAXIMUM_MULTIPLIER);
  localparam logic [7:0] MIN_M        = 8'(MINIMUM_MULTIPLIER);
  localparam logic [7:0] INIT_M       = 8'(INITIAL_MULTIPLIER);
  localparam logic [7:0] INIT_CLAMPED = (INIT_M < MIN_M) ? MIN_M :
                                        (INIT_M > MAX_M) ? MAX_M : INIT_M;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, SETTLE} state_t;

  state_t        state;
  logic [7:0]    host_tgt;
  logic [7:0]    therm_clamped;
  logic [7:0]    eff_target;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] timer;

  function automatic logic [7:0] clamp_mult(input logic [7:0] m);
    if (m < MIN_M) return MIN_M;
    if (m > MAX_M) return MAX_M;
    return m;
  endfunction

  // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    therm_clamped = clamp_mult(therm_mult);
    eff_target    = (therm_alarm && (therm_clamped < host_tgt)) ? therm_clamped : host_tgt;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_tgt    <= INIT_CLAMPED;
      target_mult <= INIT_CLAMPED;
      host_ack    <= 1'b0;
    end else begin
      host_ack    <= host_valid;
      target_mult <= eff_target;
      if (host_valid) host_tgt <= clamp_mult(host_mult);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      prog_mult    <= INIT_M;
      prog_start   <= 1'b0;
      current_mult <= INIT_CLAMPED;
      prog_error   <= 1'b0;
      ramping      <= 1'b0;
      timer        <= '0;
      settle_cnt   <= '0;
    end else begin
      prog_start <= 1'b0;
      case (state)
        IDLE: begin
          if ((current_mult != target_mult) && !prog_busy) begin
            state      <= ISSUE;
            ramping    <= 1'b1;
            prog_start <= 1'b1;
            prog_mult  <= (target_mult > current_mult) ? current_mult + 8'd1 : target_mult;
          end
        end
        ISSUE: begin
          state <= WAIT_DONE;
          timer <= '0;
        end
        WAIT_DONE: begin
          if (prog_done) begin
            current_mult <= prog_mult;
            timer        <= '0;
            settle_cnt   <= '0;
            state        <= SETTLE;
          end else if (timer == TIMEOUT_LAST) begin
            // Give up on this step; IDLE re-issues it because the target is still unmet.
            prog_error <= 1'b1;
            timer      <= '0;
            ramping    <= 1'b0;
            state      <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        SETTLE: begin
          // A falling target (thermal throttle) cuts the settle wait short.
          if ((target_mult < current_mult) || (settle_cnt == SETTLE_LAST)) begin
            settle_cnt <= '0;
            ramping    <= 1'b0;
            state      <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        default: begin
          ramping <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
